grid_renderer: RTL and testbench

GRID_RENDERER -- requirements
Module: grid_renderer

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing.sv | 67 ++++++
 rtl/grid_renderer.sv | 157 +++++++++++++++
 tb/tb_grid_renderer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing and colour constants for the grid renderer.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC_W  = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC_W + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC_W  = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC_W + V_BACK;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [11:0]      rgb_t;

  localparam rgb_t COL_BLANK  = 12'h000;
  localparam rgb_t COL_PLAYER = 12'hF00;
  localparam rgb_t COL_GRID   = 12'h444;

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, horizontal/vertical raster counters and raw (unregistered) syncs.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS  = H_VISIBLE,
  parameter int H_FP   = H_FRONT,
  parameter int H_SYNC = H_SYNC_W,
  parameter int H_TOT  = H_TOTAL,
  parameter int V_VIS  = V_VISIBLE,
  parameter int V_FP   = V_FRONT,
  parameter int V_SYNC = V_SYNC_W,
  parameter int V_TOT  = V_TOTAL
) (
  input  logic clk,
  input  logic rst,
  output logic o_pix_en,
  output cnt_t o_hcnt,
  output cnt_t o_vcnt,
  output logic o_h_last,
  output logic o_v_last,
  output logic o_h_vis,
  output logic o_v_vis,
  output logic o_visible,
  output logic o_hsync_n,
  output logic o_vsync_n
);

  logic [1:0] r_div;
  cnt_t       r_hcnt;
  cnt_t       r_vcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_div <= 2'd0;
    else     r_div <= r_div + 2'd1;
  end

  assign o_pix_en = (r_div == 2'd3);
  assign o_h_last = (r_hcnt == cnt_t'(H_TOT - 1));
  assign o_v_last = (r_vcnt == cnt_t'(V_TOT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (o_pix_en) begin
      if (o_h_last) begin
        r_hcnt <= '0;
        r_vcnt <= o_v_last ? '0 : r_vcnt + cnt_t'(1);
      end else begin
        r_hcnt <= r_hcnt + cnt_t'(1);
      end
    end
  end

  assign o_hcnt    = r_hcnt;
  assign o_vcnt    = r_vcnt;
  assign o_h_vis   = (r_hcnt < cnt_t'(H_VIS));
  assign o_v_vis   = (r_vcnt < cnt_t'(V_VIS));
  assign o_visible = o_h_vis & o_v_vis;

  // Sync pulses sit after the front porch; both are active-low.
  assign o_hsync_n = !((r_hcnt >= cnt_t'(H_VIS + H_FP)) &&
                       (r_hcnt <  cnt_t'(H_VIS + H_FP + H_SYNC)));
  assign o_vsync_n = !((r_vcnt >= cnt_t'(V_VIS + V_FP)) &&
                       (r_vcnt <  cnt_t'(V_VIS + V_FP + V_SYNC)));

endmodule

// File: rtl/grid_renderer.sv
// Draws a tile grid with one red player tile; position is latched once per frame
// at the last visible pixel so the player never tears mid-frame.
module grid_renderer
  import vga_pkg::*;
#(
  parameter int TILE_PX   = 40,
  parameter int GRID_COLS = 16,
  parameter int GRID_ROWS = 12,
  parameter int H_VIS     = H_VISIBLE,
  parameter int H_FP      = H_FRONT,
  parameter int H_SYNC    = H_SYNC_W,
  parameter int H_TOT     = H_TOTAL,
  parameter int V_VIS     = V_VISIBLE,
  parameter int V_FP      = V_FRONT,
  parameter int V_SYNC    = V_SYNC_W,
  parameter int V_TOT     = V_TOTAL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] xpos,
  input  logic [3:0] ypos,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] vgaRed,
  output logic [3:0] vgaGreen,
  output logic [3:0] vgaBlue,
  output logic       frame_tick
);

  localparam int SUB_W = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
  typedef logic [SUB_W-1:0] sub_t;
  localparam sub_t SUB_LAST = sub_t'(TILE_PX - 1);

  logic w_pix_en, w_h_last, w_v_last, w_h_vis, w_v_vis, w_visible;
  logic w_hsync_n, w_vsync_n;
  cnt_t w_hcnt, w_vcnt;

  vga_timing #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_TOT (H_TOT),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_TOT (V_TOT)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .o_pix_en  (w_pix_en),
    .o_hcnt    (w_hcnt),
    .o_vcnt    (w_vcnt),
    .o_h_last  (w_h_last),
    .o_v_last  (w_v_last),
    .o_h_vis   (w_h_vis),
    .o_v_vis   (w_v_vis),
    .o_visible (w_visible),
    .o_hsync_n (w_hsync_n),
    .o_vsync_n (w_vsync_n)
  );

  logic [7:0] r_col, r_row;
  sub_t       r_sub_x, r_sub_y;

  // Column counter only advances across the visible span, then parks until line wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col   <= '0;
      r_sub_x <= '0;
    end else if (w_pix_en) begin
      if (w_h_last) begin
        r_col   <= '0;
        r_sub_x <= '0;
      end else if (w_h_vis) begin
        if (r_sub_x == SUB_LAST) begin
          r_sub_x <= '0;
          r_col   <= r_col + 8'd1;
        end else begin
          r_sub_x <= r_sub_x + sub_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row   <= '0;
      r_sub_y <= '0;
    end else if (w_pix_en && w_h_last) begin
      if (w_v_last) begin
        r_row   <= '0;
        r_sub_y <= '0;
      end else if (w_v_vis) begin
        if (r_sub_y == SUB_LAST) begin
          r_sub_y <= '0;
          r_row   <= r_row + 8'd1;
        end else begin
          r_sub_y <= r_sub_y + sub_t'(1);
        end
      end
    end
  end

  logic       w_frame_end;
  logic [3:0] r_sx, r_sy;
  logic       r_frame_tick;

  assign w_frame_end = w_pix_en &&
                       (w_hcnt == cnt_t'(H_VIS - 1)) &&
                       (w_vcnt == cnt_t'(V_VIS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sx         <= '0;
      r_sy         <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_end;
      if (w_frame_end) begin
        r_sx <= xpos;
        r_sy <= ypos;
      end
    end
  end

  logic w_player, w_grid;
  rgb_t w_rgb;

  assign w_player = (int'(r_sx) < GRID_COLS) && (int'(r_sy) < GRID_ROWS) &&
                    (r_col == 8'(r_sx)) && (r_row == 8'(r_sy));
  assign w_grid   = (r_sub_x == '0) || (r_sub_y == '0);

  always_comb begin
    w_rgb = COL_BLANK;
    if (!w_visible)   w_rgb = COL_BLANK;
    else if (w_player) w_rgb = COL_PLAYER;
    else if (w_grid)   w_rgb = COL_GRID;
  end

  logic r_hsync, r_vsync;
  rgb_t r_rgb;

  // Syncs and colour share one register stage so they always describe the same pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= COL_BLANK;
    end else if (w_pix_en) begin
      r_hsync <= w_hsync_n;
      r_vsync <= w_vsync_n;
      r_rgb   <= w_rgb;
    end
  end

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign vgaRed     = r_rgb[11:8];
  assign vgaGreen   = r_rgb[7:4];
  assign vgaBlue    = r_rgb[3:0];
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_grid_renderer.sv
// Bench for grid_renderer: full-size instance for line timing and reset behaviour,
// reduced-geometry instance scoreboarded pixel by pixel over several frames.
module tb_grid_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- full-size instance ----------------
  logic       rst_f;
  logic [3:0] xpos_f, ypos_f;
  logic       hs_f, vs_f, ft_f;
  logic [3:0] red_f, grn_f, blu_f;

  grid_renderer u_full (
    .clk        (clk),
    .rst        (rst_f),
    .xpos       (xpos_f),
    .ypos       (ypos_f),
    .hsync      (hs_f),
    .vsync      (vs_f),
    .vgaRed     (red_f),
    .vgaGreen   (grn_f),
    .vgaBlue    (blu_f),
    .frame_tick (ft_f)
  );

  // ---------------- reduced instance: 8x4 tiles of 4 px, 48x23 raster ----------------
  localparam int S_TILE = 4;
  localparam int S_COLS = 8;
  localparam int S_ROWS = 4;
  localparam int S_HVIS = 32;
  localparam int S_HTOT = 48;
  localparam int S_VVIS = 16;
  localparam int S_VTOT = 23;
  localparam int S_FRAMES = 6;

  logic       rst_s;
  logic [3:0] xpos_s, ypos_s;
  logic       hs_s, vs_s, ft_s;
  logic [3:0] red_s, grn_s, blu_s;

  grid_renderer #(
    .TILE_PX (S_TILE), .GRID_COLS (S_COLS), .GRID_ROWS (S_ROWS),
    .H_VIS (S_HVIS), .H_FP (4), .H_SYNC (8), .H_TOT (S_HTOT),
    .V_VIS (S_VVIS), .V_FP (2), .V_SYNC (2), .V_TOT (S_VTOT)
  ) u_small (
    .clk        (clk),
    .rst        (rst_s),
    .xpos       (xpos_s),
    .ypos       (ypos_s),
    .hsync      (hs_s),
    .vsync      (vs_s),
    .vgaRed     (red_s),
    .vgaGreen   (grn_s),
    .vgaBlue    (blu_s),
    .frame_tick (ft_s)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  localparam int W = 14;               // {hsync, vsync, rgb}
  logic [W-1:0] exp_q[$];
  int           coord_q[$];            // frame<<20 | h<<10 | v
  logic [W-1:0] last_exp;

  int m_div, m_h, m_v, m_sx, m_sy, m_frame;
  int red_cnt[S_FRAMES], grey_cnt[S_FRAMES], blank_bad[S_FRAMES];
  int red_xmin[S_FRAMES], red_ymin[S_FRAMES], tick_cnt[S_FRAMES];

  function automatic logic [W-1:0] model_pix(input int h, input int v, input int sx, input int sy);
    logic       hs, vs;
    logic [11:0] c;
    hs = !(h >= 36 && h <= 43);
    vs = !(v >= 18 && v <= 19);
    if (h >= S_HVIS || v >= S_VVIS)                                   c = 12'h000;
    else if (sx < S_COLS && sy < S_ROWS && h / S_TILE == sx && v / S_TILE == sy) c = 12'hF00;
    else if (h % S_TILE == 0 || v % S_TILE == 0)                      c = 12'h444;
    else                                                              c = 12'h000;
    return {hs, vs, c};
  endfunction

  task automatic step_small();
    bit           pix;
    bit           tick_exp;
    logic [W-1:0] e, got;
    int           cd, f, h, v;
    @(posedge clk);
    pix = (m_div == 3);
    tick_exp = 1'b0;
    if (pix) begin
      exp_q.push_back(model_pix(m_h, m_v, m_sx, m_sy));
      coord_q.push_back((m_frame << 20) | (m_h << 10) | m_v);
      if (m_h == S_HVIS - 1 && m_v == S_VVIS - 1) begin
        tick_exp = 1'b1;
        m_sx = int'(xpos_s);
        m_sy = int'(ypos_s);
      end
      if (m_h == S_HTOT - 1) begin
        m_h = 0;
        if (m_v == S_VTOT - 1) begin
          m_v = 0;
          m_frame++;
        end else m_v++;
      end else m_h++;
    end
    m_div = (m_div + 1) % 4;
    @(negedge clk);
    got = {hs_s, vs_s, red_s, grn_s, blu_s};
    check_eq("frame_tick", 32'(ft_s), 32'(tick_exp));
    if (ft_s === 1'b1 && m_frame < S_FRAMES) tick_cnt[m_frame]++;
    if (pix) begin
      e  = exp_q.pop_front();
      cd = coord_q.pop_front();
      f = cd >> 20;
      h = (cd >> 10) & 1023;
      v = cd & 1023;
      check_eq("pixel", 32'(got), 32'(e));
      last_exp = e;
      if (got[11:0] == 12'hF00) begin
        red_cnt[f]++;
        if (h < red_xmin[f]) red_xmin[f] = h;
        if (v < red_ymin[f]) red_ymin[f] = v;
      end
      if (got[11:0] == 12'h444) grey_cnt[f]++;
      if ((h >= S_HVIS || v >= S_VVIS) && got[11:0] != 12'h000) blank_bad[f]++;
    end else begin
      check_eq("hold", 32'(got), 32'(last_exp));
    end
  endtask

  // Waits for hsync of the full instance to reach lvl, returning clocks elapsed.
  task automatic wait_hs(input logic lvl, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (hs_f !== lvl && n < limit);
  endtask

  // ---------------- main sequence ----------------
  int n;
  int exp_red[S_FRAMES]  = '{16, 16, 16, 0, 0, 16};
  int exp_grey[S_FRAMES] = '{217, 217, 217, 224, 224, 217};
  int exp_xmin[S_FRAMES] = '{0, 4, 8, 999, 999, 28};
  int exp_ymin[S_FRAMES] = '{0, 4, 4, 999, 999, 12};

  initial begin
    rst_f = 1'b1; rst_s = 1'b1;
    xpos_f = 4'd1; ypos_f = 4'd1;
    xpos_s = 4'd1; ypos_s = 4'd1;
    m_div = 0; m_h = 0; m_v = 0; m_sx = 0; m_sy = 0; m_frame = 0;
    last_exp = {1'b1, 1'b1, 12'h000};
    for (int i = 0; i < S_FRAMES; i++) begin
      red_cnt[i] = 0; grey_cnt[i] = 0; blank_bad[i] = 0; tick_cnt[i] = 0;
      red_xmin[i] = 999; red_ymin[i] = 999;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_full_out", 32'({hs_f, vs_f, red_f, grn_f, blu_f, ft_f}), 32'({2'b11, 12'h000, 1'b0}));
    check_eq("rst_small_out", 32'({hs_s, vs_s, red_s, grn_s, blu_s, ft_s}), 32'({2'b11, 12'h000, 1'b0}));

    // Line timing on the full-size raster.
    rst_f = 1'b0;
    wait_hs(1'b0, 4000, n);
    check_eq("hs_first_fall", n, 2628);
    check_eq("rgb_in_hblank", 32'({red_f, grn_f, blu_f}), 32'h000);
    check_eq("vs_idle", 32'(vs_f), 32'h1);
    wait_hs(1'b1, 1000, n);
    check_eq("hs_low_len", n, 384);
    wait_hs(1'b0, 4000, n);
    check_eq("hs_high_len", n, 3200 - 384);
    wait_hs(1'b1, 1000, n);
    check_eq("hs_low_len2", n, 384);

    // Reset mid-line, then restart timing from the top.
    repeat (1000) @(posedge clk);
    @(negedge clk);
    rst_f = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("midrst_out", 32'({hs_f, vs_f, red_f, grn_f, blu_f, ft_f}), 32'({2'b11, 12'h000, 1'b0}));
    end
    rst_f = 1'b0;
    wait_hs(1'b0, 4000, n);
    check_eq("hs_fall_after_midrst", n, 2628);

    // Pixel-accurate frames on the reduced raster.
    @(negedge clk);
    rst_s = 1'b0;
    for (int k = 0; k < S_FRAMES * S_HTOT * S_VTOT * 4 + 64 && m_frame < S_FRAMES; k++) begin
      step_small();
      if (m_frame == 1 && m_v >= 8) xpos_s = 4'd2;
      if (m_frame == 2) ypos_s = 4'd4;
      if (m_frame == 3) begin xpos_s = 4'd8; ypos_s = 4'd0; end
      if (m_frame == 4) begin xpos_s = 4'd7; ypos_s = 4'd3; end
    end
    check_eq("frames_run", m_frame, S_FRAMES);
    check_eq("queue_empty", exp_q.size(), 0);
    for (int f = 0; f < S_FRAMES; f++) begin
      check_eq($sformatf("red_count_f%0d", f), red_cnt[f], exp_red[f]);
      check_eq($sformatf("grey_count_f%0d", f), grey_cnt[f], exp_grey[f]);
      check_eq($sformatf("red_xmin_f%0d", f), red_xmin[f], exp_xmin[f]);
      check_eq($sformatf("red_ymin_f%0d", f), red_ymin[f], exp_ymin[f]);
      check_eq($sformatf("blank_colour_f%0d", f), blank_bad[f], 0);
      check_eq($sformatf("tick_count_f%0d", f), tick_cnt[f], 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
